// File: rtl/calc_pkg.sv
// Shared types and the opcode stepping order for the calculator sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        LOAD_A = 3'd0,
        LOAD_B = 3'd1,
        SEL_OP = 3'd2,
        EXEC   = 3'd3,
        SHOW   = 3'd4
    } calc_state_t;

    typedef logic [3:0] opcode_t;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } calc_flags_t;

    localparam opcode_t OPCODE_RESET = 4'd6;

    // Opcode cycle 0..7, 9, 14 then wrap; any other code falls back to 0.
    function automatic opcode_t next_opcode(input opcode_t op);
        case (op)
            4'd0:    next_opcode = 4'd1;
            4'd1:    next_opcode = 4'd2;
            4'd2:    next_opcode = 4'd3;
            4'd3:    next_opcode = 4'd4;
            4'd4:    next_opcode = 4'd5;
            4'd5:    next_opcode = 4'd6;
            4'd6:    next_opcode = 4'd7;
            4'd7:    next_opcode = 4'd9;
            4'd9:    next_opcode = 4'd14;
            default: next_opcode = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// Raw button to single-cycle pulse: 2-flop synchroniser, optional debounce
// (CALC_DEBOUNCE_EN), rising-edge detect.
module btn_conditioner #(
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic pulse_o
);

    logic sync_q1;
    logic sync_q2;
    logic level;
    logic level_prev;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_i;
            sync_q2 <= sync_q1;
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             db_q;

    // Debounced level flips only after DB_CYCLES consecutive differing samples.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            db_q  <= 1'b0;
        end else if (sync_q2 == db_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
            cnt_q <= '0;
            db_q  <= sync_q2;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign level = db_q;
`else
    logic unused_db;
    assign unused_db = ^DB_CYCLES;
    assign level     = sync_q2;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_prev <= 1'b0;
            pulse_o    <= 1'b0;
        end else begin
            level_prev <= level;
            pulse_o    <= level & ~level_prev;
        end
    end

endmodule

// File: rtl/calc_sequencer.sv
// Calculator front-end FSM: load A, load B, pick opcode, execute, show result.
// Optional button debounce is enabled with CALC_DEBOUNCE_EN.
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned DB_CYCLES = 250000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] sw_value_i,
    input  logic         enter_btn_i,
    input  logic         op_btn_i,
    input  logic [N-1:0] alu_result_i,
    input  logic [3:0]   alu_flags_i,
    output logic [N-1:0] alu_a_o,
    output logic [N-1:0] alu_b_o,
    output logic [3:0]   alu_opcode_o,
    output logic [N-1:0] result_o,
    output logic [3:0]   flags_o,
    output logic         mode_flag_o,
    output logic [2:0]   state_o
);

    logic enter_pulse;
    logic op_pulse;

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_enter_cond (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (enter_btn_i),
        .pulse_o (enter_pulse)
    );

    btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_op_cond (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .btn_i   (op_btn_i),
        .pulse_o (op_pulse)
    );

    calc_state_t  state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    opcode_t      op_q, op_d;
    logic [N-1:0] result_q, result_d;
    calc_flags_t  flags_q, flags_d;
    logic         mode_q, mode_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= LOAD_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OPCODE_RESET;
            result_q <= '0;
            flags_q  <= '0;
            mode_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            mode_q   <= mode_d;
        end
    end

    // Next state and next register values; enter has priority over op.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        flags_d  = flags_q;
        case (state_q)
            LOAD_A: begin
                a_d = sw_value_i;
                if (enter_pulse) state_d = LOAD_B;
            end
            LOAD_B: begin
                b_d = sw_value_i;
                if (enter_pulse) state_d = SEL_OP;
            end
            SEL_OP: begin
                if (enter_pulse)   state_d = EXEC;
                else if (op_pulse) op_d    = next_opcode(op_q);
            end
            EXEC: begin
                result_d = alu_result_i;
                flags_d  = calc_flags_t'(alu_flags_i);
                state_d  = SHOW;
            end
            SHOW: begin
                if (enter_pulse) state_d = LOAD_A;
            end
            default: state_d = LOAD_A;
        endcase
        mode_d = (state_d != SHOW);
    end

    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign alu_opcode_o = op_q;
    assign result_o     = result_q;
    assign flags_o      = flags_q;
    assign mode_flag_o  = mode_q;
    assign state_o      = state_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Randomised self-checking bench for calc_sequencer against a press-level reference model.
module tb_calc_sequencer;

`ifdef CALC_DEBOUNCE_EN
    localparam int unsigned TB_DB  = 8;
    localparam int          HOLD   = 12;
    localparam int          SETTLE = 20;
`else
    localparam int unsigned TB_DB  = 250000;
    localparam int          HOLD   = 3;
    localparam int          SETTLE = 6;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enter = 1'b0;
    logic       opb = 1'b0;
    logic [3:0] sw = 4'd0;
    logic [3:0] alu_result;
    logic [3:0] alu_flags;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_opcode;
    logic [3:0] result;
    logic [3:0] flags;
    logic       mode_flag;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    int codes [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 14};
    int m_state, m_a, m_b, m_idx, m_res, m_flg;

    always #5 clk = ~clk;

    calc_sequencer #(.N(4), .DB_CYCLES(TB_DB)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .sw_value_i   (sw),
        .enter_btn_i  (enter),
        .op_btn_i     (opb),
        .alu_result_i (alu_result),
        .alu_flags_i  (alu_flags),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_opcode_o (alu_opcode),
        .result_o     (result),
        .flags_o      (flags),
        .mode_flag_o  (mode_flag),
        .state_o      (state)
    );

    // Stand-in alu: any deterministic function of its operands serves.
    function automatic logic [3:0] ref_alu(input int op, input int a, input int b);
        logic [3:0] aa, bb, r;
        aa = 4'(a);
        bb = 4'(b);
        case (op)
            0:       r = aa + bb;
            1:       r = aa - bb;
            2:       r = aa & bb;
            3:       r = aa | bb;
            4:       r = aa ^ bb;
            5:       r = ~aa;
            6:       r = aa;
            7:       r = bb;
            9:       r = aa << 1;
            14:      r = aa >> 1;
            default: r = 4'hf;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] ref_flags(input int op, input int a, input int b);
        logic [3:0] r;
        r = ref_alu(op, a, b);
        return {r == 4'd0, r[3], (a + b) > 15, a[3] ^ b[0]};
    endfunction

    assign alu_result = ref_alu(int'(alu_opcode), int'(alu_a), int'(alu_b));
    assign alu_flags  = ref_flags(int'(alu_opcode), int'(alu_a), int'(alu_b));

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_a = 0;
        m_b = 0;
        m_idx = 6;
        m_res = 0;
        m_flg = 0;
    endtask

    task automatic check_all(input string tag);
        int exp_a, exp_b;
        exp_a = (m_state == 0) ? int'(sw) : m_a;
        exp_b = (m_state == 1) ? int'(sw) : m_b;
        check_eq({tag, " state"},  int'(state),      m_state);
        check_eq({tag, " a"},      int'(alu_a),      exp_a);
        check_eq({tag, " b"},      int'(alu_b),      exp_b);
        check_eq({tag, " opcode"}, int'(alu_opcode), codes[m_idx]);
        check_eq({tag, " result"}, int'(result),     m_res);
        check_eq({tag, " flags"},  int'(flags),      m_flg);
        check_eq({tag, " mode"},   int'(mode_flag),  (m_state != 4) ? 1 : 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst state",  int'(state),      0);
        check_eq("rst a",      int'(alu_a),      0);
        check_eq("rst b",      int'(alu_b),      0);
        check_eq("rst opcode", int'(alu_opcode), 6);
        check_eq("rst result", int'(result),     0);
        check_eq("rst flags",  int'(flags),      0);
        check_eq("rst mode",   int'(mode_flag),  1);
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    // Enter in SEL_OP: EXEC lasts one cycle, result and flags latch on leaving it.
    task automatic exec_press(input bit with_op);
        bit found;
        found = 1'b0;
        enter = 1'b1;
        opb = with_op;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (state == 3'd3) found = 1'b1;
        end
        check_eq("exec reached", int'(found), 1);
        if (found) begin
            check_eq("exec opcode held", int'(alu_opcode), codes[m_idx]);
            check_eq("exec result old",  int'(result),     m_res);
            check_eq("exec mode",        int'(mode_flag),  1);
            m_res = int'(ref_alu(codes[m_idx], m_a, m_b));
            m_flg = int'(ref_flags(codes[m_idx], m_a, m_b));
            tick();
            check_eq("exec one cycle", int'(state),     4);
            check_eq("exec result",    int'(result),    m_res);
            check_eq("exec flags",     int'(flags),     m_flg);
            check_eq("exec show mode", int'(mode_flag), 0);
        end
        m_state = 4;
        enter = 1'b0;
        opb = 1'b0;
        repeat (SETTLE) tick();
        check_all("after exec");
    endtask

    task automatic press(input bit e, input bit o);
        if (e && m_state == 2) begin
            exec_press(o);
        end else begin
            enter = e;
            opb = o;
            repeat (HOLD) tick();
            enter = 1'b0;
            opb = 1'b0;
            repeat (SETTLE) tick();
            if (e) begin
                case (m_state)
                    0: begin m_a = int'(sw); m_state = 1; end
                    1: begin m_b = int'(sw); m_state = 2; end
                    4: m_state = 0;
                    default: ;
                endcase
            end else if (o && m_state == 2) begin
                m_idx = (m_idx + 1) % 10;
            end
            check_all(e ? (o ? "both" : "enter") : "op");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        model_reset();
        do_reset();
        check_all("post reset");

        // Directed full pass: 3 op 5 with opcode stepped 6->7->9->14->0.
        sw = 4'd3;
        tick();
        press(1'b1, 1'b0);
        sw = 4'd5;
        tick();
        press(1'b1, 1'b0);
        repeat (4) press(1'b0, 1'b1);
        check_eq("pass opcode", int'(alu_opcode), 0);
        press(1'b1, 1'b0);
        check_eq("pass result", int'(result), int'(ref_alu(0, 3, 5)));

        // Wrap: ten op presses return to the reset opcode.
        do_reset();
        press(1'b0, 1'b1);
        check_eq("op in load_a", int'(alu_opcode), 6);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        repeat (10) press(1'b0, 1'b1);
        check_eq("wrap opcode", int'(alu_opcode), 6);

        // Collision: enter wins, opcode unchanged.
        press(1'b1, 1'b1);
        check_eq("collide state", int'(state), 4);

        // Reset while in EXEC aborts without latching.
        sw = 4'd9;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        enter = 1'b1;
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 40 && !found; i++) begin
                tick();
                if (state == 3'd3) found = 1'b1;
            end
            check_eq("midop exec reached", int'(found), 1);
        end
        rst = 1'b1;
        tick();
        check_eq("midop state",  int'(state),     0);
        check_eq("midop result", int'(result),    0);
        check_eq("midop flags",  int'(flags),     0);
        check_eq("midop mode",   int'(mode_flag), 1);
        enter = 1'b0;
        tick();
        rst = 1'b0;
        model_reset();
        repeat (SETTLE) tick();
        check_all("midop after");

`ifdef CALC_DEBOUNCE_EN
        // Short glitch is filtered; a long press advances exactly once.
        enter = 1'b1;
        repeat (5) tick();
        enter = 1'b0;
        repeat (SETTLE) tick();
        check_eq("glitch state", int'(state), 0);
        enter = 1'b1;
        repeat (12) tick();
        enter = 1'b0;
        repeat (SETTLE) tick();
        check_eq("long press state", int'(state), 1);
        m_a = int'(sw);
        m_state = 1;
`endif

        // Randomised sequence of switch changes, presses and occasional resets.
        for (int k = 0; k < 150; k++) begin
            int act;
            act = int'($urandom_range(0, 9));
            if ($urandom_range(0, 29) == 0) begin
                do_reset();
                check_all("rand reset");
            end else if (act <= 2) begin
                sw = 4'($urandom);
                tick();
                check_all("rand sw");
            end else if (act <= 5) begin
                press(1'b1, 1'b0);
            end else if (act <= 8) begin
                press(1'b0, 1'b1);
            end else begin
                press(1'b1, 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
